pwm_capture: RTL

Measures a pulse-width-modulated input and reports the high time and period of each pulse as integer cycle counts. It is the receive-side counterpart of the DAC's PWM output. It sits on the loopback and test path: the `pwm_out` pin is fed back, and the bench or host logic compares the recovered `pulse_width` and period against what was programmed. The input is asynchronous and is synchronized internally. Completed measurements go out through a one-entry valid/ready register with sticky overrun reporting.

---
 rtl/pwm_capture_pkg.sv | 27 ++
 rtl/bit_synchronizer.sv | 34 +++
 rtl/pwm_capture.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pwm_capture_pkg.sv
// -----------------------------------------------------------------------------
// pwm_capture_pkg
// Shared types for the PWM capture block and for host-side logic that
// consumes its measurements.
//   PWM_BITS            default counter / measurement width
//   pwm_capture_state_t capture FSM states (IDLE, HIGH, LOW)
//   pwm_meas_t          one measurement: high time, period, timeout flag
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package pwm_capture_pkg;

    localparam int PWM_BITS = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_capture_state_t;

    typedef struct packed {
        logic [PWM_BITS-1:0] high;
        logic [PWM_BITS-1:0] period;
        logic                timeout;
    } pwm_meas_t;

endpackage

// File: rtl/bit_synchronizer.sv
// -----------------------------------------------------------------------------
// bit_synchronizer
// Multi-flop synchronizer for a single asynchronous level into the clk domain.
// Reusable for any slow pin input.
//   STAGES  number of flops in the chain (2 or more)
//   clk     destination clock
//   reset   asynchronous, active-high; clears the chain to 0
//   d       asynchronous input level
//   q       synchronized level, STAGES cycles behind d
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
// Measures high time and period of an asynchronous PWM input in clk cycles.
// A window ends on a rising edge (from HIGH or LOW) or on a timeout; the
// first, partial window after reset is discarded. Results leave through a
// one-entry valid/ready register; a result arriving while the register is
// full and not being read is dropped and flagged in a sticky overrun bit.
//   BITS, SYNC_STAGES  counter width, synchronizer depth
//   clk, reset         clock, asynchronous active-high reset
//   pwm_in             asynchronous PWM input
//   timeout_max        period timeout in cycles (0 = only the all-ones limit)
//   meas_valid/ready   output handshake
//   meas_high/period   measured high and total cycles
//   meas_timeout       window was closed by timeout rather than a rise
//   overrun/_clr       sticky drop flag and its clear
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int BITS        = 11,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pwm_in,
    input  logic [BITS-1:0] timeout_max,
    output logic            meas_valid,
    input  logic            meas_ready,
    output logic [BITS-1:0] meas_high,
    output logic [BITS-1:0] meas_period,
    output logic            meas_timeout,
    output logic            overrun,
    input  logic            overrun_clr
);

    typedef struct packed {
        logic [BITS-1:0] high;
        logic [BITS-1:0] period;
        logic            timeout;
    } meas_t;

    logic               s;
    logic               s_d;
    logic               rise;
    logic               fall;
    pwm_capture_state_t state;
    pwm_capture_state_t state_d;
    logic [BITS-1:0]    period_cnt;
    logic [BITS-1:0]    high_cnt;
    logic               timeout_hit;
    logic               edge_emit;
    logic               emit;
    logic               slot_free;
    meas_t              new_meas;

    // ---- input synchronization and edge detection ----
    bit_synchronizer #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (pwm_in),
        .q    (s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_d <= 1'b0;
        end else begin
            s_d <= s;
        end
    end

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    // ---- capture FSM ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Edges alone drive the state; a timeout never changes it.
    always_comb begin
        state_d = state;
        if (rise) begin
            state_d = HIGH;
        end else if (fall) begin
            state_d = LOW;
        end
    end

    // ---- window counters and completion ----
    // The all-ones check keeps period_cnt from ever wrapping, so high_cnt
    // (never larger than period_cnt) cannot wrap either.
    assign timeout_hit = ~rise &
                         (((timeout_max != '0) && (period_cnt >= timeout_max)) ||
                          (&period_cnt));
    // A rise out of IDLE only opens the first window; nothing to report yet.
    assign edge_emit   = rise && (state != IDLE);
    assign emit        = edge_emit || timeout_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_cnt <= '0;
            high_cnt   <= '0;
        end else if (rise) begin
            // The rise cycle itself is high and belongs to the new window.
            period_cnt <= BITS'(1);
            high_cnt   <= BITS'(1);
        end else if (timeout_hit) begin
            period_cnt <= '0;
            high_cnt   <= '0;
        end else begin
            period_cnt <= period_cnt + BITS'(1);
            high_cnt   <= high_cnt + BITS'(s);
        end
    end

    // ---- one-entry output register ----
    assign slot_free = ~meas_valid | meas_ready;

    always_comb begin
        new_meas         = '0;
        new_meas.high    = high_cnt;
        new_meas.period  = period_cnt;
        new_meas.timeout = ~edge_emit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meas_valid   <= 1'b0;
            meas_high    <= '0;
            meas_period  <= '0;
            meas_timeout <= 1'b0;
        end else if (emit && slot_free) begin
            meas_valid   <= 1'b1;
            meas_high    <= new_meas.high;
            meas_period  <= new_meas.period;
            meas_timeout <= new_meas.timeout;
        end else if (meas_valid && meas_ready) begin
            meas_valid   <= 1'b0;
        end
    end

    // A drop on the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (emit && !slot_free) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule
